// File: rtl/return_addr_stack.sv
// Return-address stack for jr $ra target prediction, with mispredict detection at EX.
// Define RAS_STATS_EN to add saturating hit/miss counters (hit_cnt, miss_cnt).
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    output logic [AW-1:0] top_addr,
    output logic          top_valid,
    input  logic          resolve,
    input  logic [AW-1:0] ex_target,
    input  logic          flush,
    output logic          mispredict,
    output logic [AW-1:0] redirect,
    output logic          underflow
`ifdef RAS_STATS_EN
   ,output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_tos;
    logic [PW:0]   r_count;
    logic [AW-1:0] r_pend_addr;
    logic          r_pend_valid;
    logic          r_mispredict;
    logic [AW-1:0] r_redirect;
    logic          r_underflow;

    logic          w_empty;
    logic [PW-1:0] w_top_idx;
    logic [AW-1:0] w_top;
    logic [AW-1:0] w_push_data;
    logic          w_wr_en;
    logic [PW-1:0] w_wr_idx;
    logic [PW-1:0] w_tos_next;
    logic [PW:0]   w_count_next;
    logic          w_res_eff;
    logic          w_miss;

    assign w_empty     = (r_count == '0);
    assign w_top_idx   = r_tos - PW'(1);
    assign w_top       = w_empty ? '0 : r_mem[w_top_idx];
    assign w_push_data = push_pc + AW'(4);
    assign w_res_eff   = resolve & ~flush;
    assign w_miss      = ~r_pend_valid | (r_pend_addr != ex_target);

    // A tail-call (push+pop on a non-empty stack) rewrites the top slot in place.
    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_idx     = r_tos;
        w_tos_next   = r_tos;
        w_count_next = r_count;
        if (push && pop && !w_empty) begin
            w_wr_en  = 1'b1;
            w_wr_idx = w_top_idx;
        end else if (push) begin
            w_wr_en      = 1'b1;
            w_tos_next   = r_tos + PW'(1);
            w_count_next = (r_count == FULL) ? FULL : r_count + (PW+1)'(1);
        end else if (pop && !w_empty) begin
            w_tos_next   = w_top_idx;
            w_count_next = r_count - (PW+1)'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[gi] <= '0;
                end else if (w_wr_en && (w_wr_idx == PW'(gi))) begin
                    r_mem[gi] <= w_push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tos        <= '0;
            r_count      <= '0;
            r_pend_addr  <= '0;
            r_pend_valid <= 1'b0;
            r_mispredict <= 1'b0;
            r_redirect   <= '0;
            r_underflow  <= 1'b0;
        end else begin
            r_tos        <= w_tos_next;
            r_count      <= w_count_next;
            r_underflow  <= pop & w_empty;
            r_mispredict <= w_res_eff & w_miss;
            r_redirect   <= w_res_eff ? ex_target : '0;
            // The resolve compare above uses the old pend; a same-cycle pop reloads it.
            if (pop) begin
                r_pend_addr  <= w_top;
                r_pend_valid <= 1'b1;
            end else if (resolve || flush) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

`ifdef RAS_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_res_eff) begin
            if (w_miss) begin
                if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end else begin
                if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    assign top_addr   = w_top;
    assign top_valid  = ~w_empty;
    assign mispredict = r_mispredict;
    assign redirect   = r_redirect;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed, table-driven checks of return_addr_stack plus hand-written reset sequences.
module tb_return_addr_stack;

    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic [AW-1:0] push_pc;
    logic          pop;
    logic [AW-1:0] top_addr;
    logic          top_valid;
    logic          resolve;
    logic [AW-1:0] ex_target;
    logic          flush;
    logic          mispredict;
    logic [AW-1:0] redirect;
    logic          underflow;
`ifdef RAS_STATS_EN
    logic [15:0]   hit_cnt;
    logic [15:0]   miss_cnt;
`endif

    return_addr_stack #(.DEPTH(8), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .push(push), .push_pc(push_pc), .pop(pop),
        .top_addr(top_addr), .top_valid(top_valid),
        .resolve(resolve), .ex_target(ex_target), .flush(flush),
        .mispredict(mispredict), .redirect(redirect), .underflow(underflow)
`ifdef RAS_STATS_EN
       ,.hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          push;
        logic [AW-1:0] pc;
        logic          pop;
        logic          res;
        logic [AW-1:0] ext;
        logic          flush;
        logic [AW-1:0] e_top;
        logic          e_valid;
        logic          e_mis;
        logic [AW-1:0] e_red;
        logic          e_uf;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic p, input logic [AW-1:0] pc, input logic o,
                       input logic r, input logic [AW-1:0] ext, input logic f,
                       input logic [AW-1:0] et, input logic ev, input logic em,
                       input logic [AW-1:0] er, input logic eu);
        vec_t v;
        v.push = p; v.pc = pc; v.pop = o; v.res = r; v.ext = ext; v.flush = f;
        v.e_top = et; v.e_valid = ev; v.e_mis = em; v.e_red = er; v.e_uf = eu;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        push = 1'b0; push_pc = '0; pop = 1'b0;
        resolve = 1'b0; ex_target = '0; flush = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] exp_top;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_top_addr", top_addr, '0);
        chk("reset_top_valid", {31'd0, top_valid}, '0);
        chk("reset_mispredict", {31'd0, mispredict}, '0);
        chk("reset_underflow", {31'd0, underflow}, '0);
        rst_n = 1'b1;

        //   push pc      pop res ext       fl  top       v  mis red    uf
        add(0, 0,         0, 0, 0,        0, 0,        0, 0, 0,     0);
        // T1
        add(1, 'h100,     0, 0, 0,        0, 'h104,    1, 0, 0,     0);
        add(0, 0,         1, 0, 0,        0, 0,        0, 0, 0,     0);
        add(0, 0,         0, 1, 'h104,    0, 0,        0, 0, 0,     0);
        // T2
        add(1, 'h200,     0, 0, 0,        0, 'h204,    1, 0, 0,     0);
        add(0, 0,         1, 0, 0,        0, 0,        0, 0, 0,     0);
        add(0, 0,         0, 1, 'h300,    0, 0,        0, 1, 'h300, 0);
        add(0, 0,         0, 0, 0,        0, 0,        0, 0, 0,     0);
        // T3: nine pushes wrap a depth-8 stack
        for (int k = 0; k < 9; k++)
            add(1, 32'(k*16), 0, 0, 0, 0, 32'(k*16+4), 1, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            exp_top = (j < 7) ? 32'('h84 - 16*(j+1)) : '0;
            add(0, 0, 1, 0, 0, 0, exp_top, (j < 7), 0, 0, 0);
            add(0, 0, 0, 1, 32'('h84 - 16*j), 0, exp_top, (j < 7), 0, 0, 0);
        end
        // T5: pop on empty, then resolve
        add(0, 0,         1, 0, 0,        0, 0,        0, 0, 0,     1);
        add(0, 0,         0, 1, 'h40,     0, 0,        0, 1, 'h40,  0);
        add(0, 0,         0, 0, 0,        0, 0,        0, 0, 0,     0);
        // T4: tail-call
        add(1, 'h400,     0, 0, 0,        0, 'h404,    1, 0, 0,     0);
        add(1, 'h500,     1, 0, 0,        0, 'h504,    1, 0, 0,     0);
        add(0, 0,         0, 1, 'h404,    0, 'h504,    1, 0, 0,     0);
        add(0, 0,         1, 0, 0,        0, 0,        0, 0, 0,     0);
        add(0, 0,         0, 1, 'h504,    0, 0,        0, 0, 0,     0);
        // flush drops the pending prediction and masks resolve
        add(1, 'h600,     0, 0, 0,        0, 'h604,    1, 0, 0,     0);
        add(0, 0,         1, 0, 0,        0, 0,        0, 0, 0,     0);
        add(0, 0,         0, 1, 'h999,    1, 0,        0, 0, 0,     0);
        add(0, 0,         0, 1, 'h604,    0, 0,        0, 1, 'h604, 0);
        // push+pop on empty: underflow and count becomes 1
        add(1, 'h700,     1, 0, 0,        0, 'h704,    1, 0, 0,     1);
        add(0, 0,         0, 1, 'h44,     0, 'h704,    1, 1, 'h44,  0);
        add(0, 0,         1, 0, 0,        0, 0,        0, 0, 0,     0);
        add(0, 0,         0, 1, 'h704,    0, 0,        0, 0, 0,     0);
        // pop and resolve together compare against the older prediction
        add(1, 'h800,     0, 0, 0,        0, 'h804,    1, 0, 0,     0);
        add(1, 'h900,     0, 0, 0,        0, 'h904,    1, 0, 0,     0);
        add(0, 0,         1, 0, 0,        0, 'h804,    1, 0, 0,     0);
        add(0, 0,         1, 1, 'h904,    0, 0,        0, 0, 0,     0);
        add(0, 0,         0, 1, 'h111,    0, 0,        0, 1, 'h111, 0);
        // push_pc+4 drops the carry
        add(1, 'hFFFFFFFC,0, 0, 0,        0, 0,        1, 0, 0,     0);
        add(0, 0,         1, 0, 0,        0, 0,        0, 0, 0,     0);
        add(0, 0,         0, 1, 0,        0, 0,        0, 0, 0,     0);

        for (int i = 0; i < vecs.size(); i++) begin
            push = vecs[i].push; push_pc = vecs[i].pc; pop = vecs[i].pop;
            resolve = vecs[i].res; ex_target = vecs[i].ext; flush = vecs[i].flush;
            @(posedge clk);
            @(negedge clk);
            $display("vec %0d: push=%0d pc=0x%0h pop=%0d res=%0d ext=0x%0h flush=%0d -> top=0x%0h v=%0d mis=%0d red=0x%0h uf=%0d",
                     i, vecs[i].push, vecs[i].pc, vecs[i].pop, vecs[i].res, vecs[i].ext,
                     vecs[i].flush, top_addr, top_valid, mispredict, redirect, underflow);
            chk($sformatf("vec%0d_top_addr", i), top_addr, vecs[i].e_top);
            chk($sformatf("vec%0d_top_valid", i), {31'd0, top_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d_mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
            chk($sformatf("vec%0d_underflow", i), {31'd0, underflow}, {31'd0, vecs[i].e_uf});
            if (vecs[i].e_mis)
                chk($sformatf("vec%0d_redirect", i), redirect, vecs[i].e_red);
`ifdef RAS_STATS_EN
            if (i == 7) begin
                chk("stats_hit_after_t2", {16'd0, hit_cnt}, 32'd1);
                chk("stats_miss_after_t2", {16'd0, miss_cnt}, 32'd1);
            end
`endif
        end
        idle_inputs();

        // T6: asynchronous reset while a mispredict pulse and a pop are in flight
        push = 1'b1; push_pc = 'h100;
        @(negedge clk);
        push_pc = 'h200;
        @(negedge clk);
        push = 1'b0; pop = 1'b1;
        @(negedge clk);
        pop = 1'b0; resolve = 1'b1; ex_target = 'h999;
        @(negedge clk);
        $display("t6 pre-reset: top=0x%0h v=%0d mis=%0d red=0x%0h", top_addr, top_valid, mispredict, redirect);
        chk("t6_pre_mispredict", {31'd0, mispredict}, 32'd1);
        chk("t6_pre_top_addr", top_addr, 'h104);
        resolve = 1'b0; pop = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        $display("t6 in reset: top=0x%0h v=%0d mis=%0d red=0x%0h uf=%0d", top_addr, top_valid, mispredict, redirect, underflow);
        chk("t6_rst_top_addr", top_addr, '0);
        chk("t6_rst_top_valid", {31'd0, top_valid}, '0);
        chk("t6_rst_mispredict", {31'd0, mispredict}, '0);
        chk("t6_rst_redirect", redirect, '0);
        chk("t6_rst_underflow", {31'd0, underflow}, '0);
`ifdef RAS_STATS_EN
        chk("t6_rst_hit_cnt", {16'd0, hit_cnt}, '0);
        chk("t6_rst_miss_cnt", {16'd0, miss_cnt}, '0);
`endif
        repeat (2) @(negedge clk);
        chk("t6_hold_underflow", {31'd0, underflow}, '0);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        $display("t6 post-reset: top=0x%0h v=%0d mis=%0d uf=%0d", top_addr, top_valid, mispredict, underflow);
        chk("t6_post_underflow", {31'd0, underflow}, '0);
        chk("t6_post_mispredict", {31'd0, mispredict}, '0);
        chk("t6_post_top_valid", {31'd0, top_valid}, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
